// File: rtl/capture_sequencer_if.sv
// rtl/capture_sequencer_if.sv - bus bundle between the decimators, the sequencer and the DSP side
//
// Groups every non-clock signal of capture_sequencer.
//   slave  : the sequencer. It receives the channel samples, valids and controls,
//            and drives the RAM write port and status.
//   master : the surrounding logic. It drives the samples and controls, and
//            observes the write port and status.
// Channel inputs : chanA..chanD, chanAvalid..chanDvalid
// Controls       : arm, abort, force_trig, ack, threshold
// RAM write port : wr_en, wr_addr, wr_data
// Status         : data_rdy, busy, overrun, trig_chan, state
interface capture_sequencer_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] chanA;
   logic [DATA_W-1:0] chanB;
   logic [DATA_W-1:0] chanC;
   logic [DATA_W-1:0] chanD;
   logic              chanAvalid;
   logic              chanBvalid;
   logic              chanCvalid;
   logic              chanDvalid;
   logic              arm;
   logic              abort;
   logic              force_trig;
   logic              ack;
   logic [14:0]       threshold;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              data_rdy;
   logic              busy;
   logic [3:0]        overrun;
   logic [3:0]        trig_chan;
   logic [1:0]        state;

   modport master (
      output chanA, chanB, chanC, chanD,
      output chanAvalid, chanBvalid, chanCvalid, chanDvalid,
      output arm, abort, force_trig, ack, threshold,
      input  wr_en, wr_addr, wr_data, data_rdy, busy, overrun, trig_chan, state
   );

   modport slave (
      input  chanA, chanB, chanC, chanD,
      input  chanAvalid, chanBvalid, chanCvalid, chanDvalid,
      input  arm, abort, force_trig, ack, threshold,
      output wr_en, wr_addr, wr_data, data_rdy, busy, overrun, trig_chan, state
   );
endinterface

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - triggered four-channel capture into one shared sample RAM
//
// Waits for arm, then for a magnitude trigger (or force_trig). It then collects
// NUM_FRAMES samples per channel into the RAM through a single round-robin
// write port. Each sample is stored at address {frame, chan}.
// Ports:
//   adcClk : sample clock. All logic runs on its rising edge.
//   rst    : asynchronous reset, active low.
//   bus    : capture_sequencer_if.slave. It carries the channel samples and
//            valids, the controls (arm, abort, force_trig, ack, threshold),
//            the RAM write port (wr_en, wr_addr, wr_data) and the status
//            (data_rdy, busy, overrun, trig_chan, state).
module capture_sequencer #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 16,
   parameter int NUM_FRAMES = 1024
) (
   input logic                adcClk,
   input logic                rst,
   capture_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

   // The magnitude and the 15-bit threshold are compared at a common width.
   localparam int MAG_W = (DATA_W - 1 > 15) ? DATA_W - 1 : 15;
   localparam logic [ADDR_W-2:0] FRAMES = (ADDR_W - 1)'(NUM_FRAMES);

   state_t            stateReg;
   logic [DATA_W-1:0] holdReg     [4];
   logic [ADDR_W-2:0] sampleCount [4];
   logic [3:0]        pending;
   logic [1:0]        rrPtr;

   logic [DATA_W-1:0] chanData [4];
   logic [3:0]        chanValid;
   logic [3:0]        hitVec;
   logic              grantValid;
   logic [1:0]        grantIdx;
   logic [1:0]        cand;
   logic              allFull;

   // |x|, with the most negative code saturated to the largest positive one
   function automatic logic [DATA_W-2:0] magOf(input logic [DATA_W-1:0] s);
      logic [DATA_W-1:0] neg;
      neg = ~s + 1'b1;
      if (!s[DATA_W-1])
         magOf = s[DATA_W-2:0];
      else if (s[DATA_W-2:0] == '0)
         magOf = '1;
      else
         magOf = neg[DATA_W-2:0];
   endfunction

   always_comb begin
      chanData[0] = bus.chanA;
      chanData[1] = bus.chanB;
      chanData[2] = bus.chanC;
      chanData[3] = bus.chanD;
      chanValid   = {bus.chanDvalid, bus.chanCvalid, bus.chanBvalid, bus.chanAvalid};
   end

   always_comb begin
      hitVec = '0;
      for (int k = 0; k < 4; k++)
         hitVec[k] = chanValid[k] && (MAG_W'(magOf(chanData[k])) >= MAG_W'(bus.threshold));
   end

   // The scan runs from the farthest offset down to offset 0. The nearest
   // pending channel to rrPtr is therefore the last one assigned, and it wins.
   // The grant uses only the registered pending bits.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = rrPtr;
      cand       = rrPtr;
      for (int k = 3; k >= 0; k--) begin
         cand = rrPtr + 2'(k);
         if (pending[cand]) begin
            grantValid = 1'b1;
            grantIdx   = cand;
         end
      end
   end

   always_comb begin
      allFull = 1'b1;
      for (int k = 0; k < 4; k++)
         if (sampleCount[k] != FRAMES) allFull = 1'b0;
   end

   assign bus.state = stateReg;

   always_ff @(posedge adcClk or negedge rst) begin
      if (!rst) begin
         stateReg      <= IDLE;
         pending       <= '0;
         rrPtr         <= '0;
         bus.wr_en     <= 1'b0;
         bus.wr_addr   <= '0;
         bus.wr_data   <= '0;
         bus.data_rdy  <= 1'b0;
         bus.busy      <= 1'b0;
         bus.overrun   <= '0;
         bus.trig_chan <= '0;
         for (int k = 0; k < 4; k++) begin
            holdReg[k]     <= '0;
            sampleCount[k] <= '0;
         end
      end else begin
         bus.wr_en <= 1'b0;
         if (bus.abort) begin
            // overrun and trig_chan stay visible until the next arm.
            stateReg     <= IDLE;
            pending      <= '0;
            bus.data_rdy <= 1'b0;
            bus.busy     <= 1'b0;
         end else begin
            case (stateReg)
               IDLE: begin
                  if (bus.arm) begin
                     stateReg      <= ARMED;
                     bus.busy      <= 1'b1;
                     bus.overrun   <= '0;
                     bus.trig_chan <= '0;
                     pending       <= '0;
                     rrPtr         <= '0;
                     for (int k = 0; k < 4; k++) sampleCount[k] <= '0;
                  end
               end
               ARMED: begin
                  if ((|hitVec) || bus.force_trig) begin
                     stateReg      <= CAPTURE;
                     bus.trig_chan <= hitVec;
                     // Samples present in the trigger cycle become index 0.
                     for (int k = 0; k < 4; k++) begin
                        if (chanValid[k]) begin
                           holdReg[k] <= chanData[k];
                           pending[k] <= 1'b1;
                        end
                     end
                  end
               end
               CAPTURE: begin
                  if (allFull && pending == '0) begin
                     stateReg     <= DONE;
                     bus.data_rdy <= 1'b1;
                     bus.busy     <= 1'b0;
                  end else begin
                     if (grantValid) begin
                        bus.wr_en             <= 1'b1;
                        bus.wr_addr           <= {sampleCount[grantIdx][ADDR_W-3:0], grantIdx};
                        bus.wr_data           <= holdReg[grantIdx];
                        pending[grantIdx]     <= 1'b0;
                        sampleCount[grantIdx] <= sampleCount[grantIdx] + 1'b1;
                        rrPtr                 <= grantIdx + 2'd1;
                     end
                     // A granted channel still counts as pending this cycle,
                     // so a new sample on that channel is dropped.
                     for (int k = 0; k < 4; k++) begin
                        if (chanValid[k]) begin
                           if (pending[k])
                              bus.overrun[k] <= 1'b1;
                           else if (sampleCount[k] < FRAMES) begin
                              holdReg[k] <= chanData[k];
                              pending[k] <= 1'b1;
                           end
                        end
                     end
                  end
               end
               DONE: begin
                  if (bus.ack) begin
                     stateReg     <= IDLE;
                     bus.data_rdy <= 1'b0;
                  end
               end
               default: stateReg <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - directed self-checking bench for capture_sequencer
//
// Drives the sequencer through its capture scenarios and compares the outputs
// with hand-computed values. The DUT ports are the clock, the reset and the
// capture_sequencer_if bundle.
module tb_capture_sequencer;
   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 16;
   localparam int NUM_FRAMES = 4;

   logic adcClk = 1'b0;
   logic rst    = 1'b0;

   capture_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   capture_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_FRAMES(NUM_FRAMES)) dut (
      .adcClk (adcClk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 adcClk = ~adcClk;

   int nChecks = 0;
   int nPass   = 0;

   // Write log, sampled on the falling edge
   logic [ADDR_W-1:0] logAddr [256];
   logic [DATA_W-1:0] logData [256];
   logic              logRdy  [256];
   int                wrCount = 0;

   always @(negedge adcClk) begin
      if (bus.wr_en === 1'b1 && wrCount < 256) begin
         logAddr[wrCount] <= bus.wr_addr;
         logData[wrCount] <= bus.wr_data;
         logRdy[wrCount]  <= bus.data_rdy;
         wrCount          <= wrCount + 1;
      end
   end

   task automatic cyc();
      @(posedge adcClk);
      #1;
   endtask

   task automatic clearValids();
      bus.chanAvalid = 1'b0;
      bus.chanBvalid = 1'b0;
      bus.chanCvalid = 1'b0;
      bus.chanDvalid = 1'b0;
   endtask

   task automatic setFrame(input int a, input int b, input int c, input int d, input logic [3:0] mask);
      bus.chanA      = DATA_W'(a);
      bus.chanB      = DATA_W'(b);
      bus.chanC      = DATA_W'(c);
      bus.chanD      = DATA_W'(d);
      bus.chanAvalid = mask[0];
      bus.chanBvalid = mask[1];
      bus.chanCvalid = mask[2];
      bus.chanDvalid = mask[3];
   endtask

   task automatic pulseArm();   bus.arm = 1'b1;   cyc(); bus.arm = 1'b0;   endtask
   task automatic pulseAbort(); bus.abort = 1'b1; cyc(); bus.abort = 1'b0; endtask
   task automatic pulseAck();   bus.ack = 1'b1;   cyc(); bus.ack = 1'b0;   endtask

   task automatic test_reset();
      bus.threshold = 15'd0;
      bus.arm = 1'b0; bus.abort = 1'b0; bus.force_trig = 1'b0; bus.ack = 1'b0;
      setFrame(0, 0, 0, 0, 4'b0000);
      rst = 1'b0;
      repeat (2) cyc();
      nChecks++; if (bus.state !== 2'd0)     $display("FAIL reset_state got %0d want 0", bus.state); else nPass++;
      nChecks++; if (bus.wr_en !== 1'b0)     $display("FAIL reset_wr_en got %b want 0", bus.wr_en); else nPass++;
      nChecks++; if (bus.wr_addr !== '0)     $display("FAIL reset_wr_addr got %0h want 0", bus.wr_addr); else nPass++;
      nChecks++; if (bus.data_rdy !== 1'b0)  $display("FAIL reset_data_rdy got %b want 0", bus.data_rdy); else nPass++;
      nChecks++; if (bus.busy !== 1'b0)      $display("FAIL reset_busy got %b want 0", bus.busy); else nPass++;
      nChecks++; if (bus.overrun !== 4'h0)   $display("FAIL reset_overrun got %b want 0", bus.overrun); else nPass++;
      nChecks++; if (bus.trig_chan !== 4'h0) $display("FAIL reset_trig_chan got %b want 0", bus.trig_chan); else nPass++;
      rst = 1'b1;
      cyc();
   endtask

   task automatic test_simultaneous();
      logic [DATA_W-1:0] expD [4];
      expD[0] = 16'd500; expD[1] = 16'hFB50; expD[2] = 16'd0; expD[3] = 16'd999;
      bus.threshold = 15'd1000;
      pulseArm();
      nChecks++; if (bus.state !== 2'd1) $display("FAIL sim_armed got %0d want 1", bus.state); else nPass++;
      nChecks++; if (bus.busy !== 1'b1)  $display("FAIL sim_busy got %b want 1", bus.busy); else nPass++;
      setFrame(500, -1200, 0, 999, 4'b1111);
      cyc();
      clearValids();
      nChecks++; if (bus.state !== 2'd2)        $display("FAIL sim_capture got %0d want 2", bus.state); else nPass++;
      nChecks++; if (bus.trig_chan !== 4'b0010) $display("FAIL sim_trig_chan got %b want 0010", bus.trig_chan); else nPass++;
      nChecks++; if (bus.wr_en !== 1'b0)        $display("FAIL sim_no_early_write got %b want 0", bus.wr_en); else nPass++;
      for (int i = 0; i < 4; i++) begin
         cyc();
         nChecks++; if (bus.wr_en !== 1'b1) $display("FAIL sim_wr_en[%0d] got %b want 1", i, bus.wr_en); else nPass++;
         nChecks++; if (bus.wr_addr !== ADDR_W'(i)) $display("FAIL sim_addr[%0d] got %0d want %0d", i, bus.wr_addr, i); else nPass++;
         nChecks++; if (bus.wr_data !== expD[i]) $display("FAIL sim_data[%0d] got %0h want %0h", i, bus.wr_data, expD[i]); else nPass++;
      end
      cyc();
      nChecks++; if (bus.wr_en !== 1'b0) $display("FAIL sim_idle_port got %b want 0", bus.wr_en); else nPass++;
      pulseAbort();
      nChecks++; if (bus.state !== 2'd0) $display("FAIL sim_abort got %0d want 0", bus.state); else nPass++;
   endtask

   task automatic test_threshold_sat();
      bus.threshold = 15'd32767;
      pulseArm();
      setFrame(0, 32766, 0, 0, 4'b0010);
      cyc();
      clearValids();
      nChecks++; if (bus.state !== 2'd1) $display("FAIL sat_below got %0d want 1", bus.state); else nPass++;
      setFrame(-32768, 0, 0, 0, 4'b0001);
      cyc();
      clearValids();
      nChecks++; if (bus.state !== 2'd2)        $display("FAIL sat_trig got %0d want 2", bus.state); else nPass++;
      nChecks++; if (bus.trig_chan !== 4'b0001) $display("FAIL sat_trig_chan got %b want 0001", bus.trig_chan); else nPass++;
      cyc();
      nChecks++; if (bus.wr_en !== 1'b1 || bus.wr_data !== 16'h8000 || bus.wr_addr !== '0)
         $display("FAIL sat_write got en=%b addr=%0d data=%0h want en=1 addr=0 data=8000", bus.wr_en, bus.wr_addr, bus.wr_data);
      else nPass++;
      pulseAbort();
   endtask

   task automatic test_overrun_rr();
      logic [ADDR_W-1:0] expA [4];
      logic [DATA_W-1:0] expD [4];
      expA[0] = 12'd1; expA[1] = 12'd2; expA[2] = 12'd3; expA[3] = 12'd4;
      expD[0] = 16'd33; expD[1] = 16'd44; expD[2] = 16'd55; expD[3] = 16'd22;
      bus.threshold = 15'd32767;
      pulseArm();
      nChecks++; if (bus.overrun !== 4'b0000) $display("FAIL ovr_cleared_by_arm got %b want 0000", bus.overrun); else nPass++;
      bus.force_trig = 1'b1;
      cyc();
      bus.force_trig = 1'b0;
      nChecks++; if (bus.trig_chan !== 4'b0000) $display("FAIL ovr_force_trig_chan got %b want 0000", bus.trig_chan); else nPass++;
      // A lone A sample moves rrPtr to 1.
      setFrame(11, 0, 0, 0, 4'b0001);
      cyc();
      clearValids();
      cyc();
      nChecks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== '0 || bus.wr_data !== 16'd11)
         $display("FAIL ovr_first_a got en=%b addr=%0d data=%0d want en=1 addr=0 data=11", bus.wr_en, bus.wr_addr, bus.wr_data);
      else nPass++;
      setFrame(22, 33, 44, 55, 4'b1111);
      cyc();
      setFrame(66, 0, 0, 0, 4'b0001);
      cyc();
      clearValids();
      nChecks++; if (bus.overrun !== 4'b0001) $display("FAIL ovr_flag got %b want 0001", bus.overrun); else nPass++;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) cyc();
         nChecks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== expA[i] || bus.wr_data !== expD[i])
            $display("FAIL ovr_grant[%0d] got en=%b addr=%0d data=%0d want en=1 addr=%0d data=%0d",
                     i, bus.wr_en, bus.wr_addr, bus.wr_data, expA[i], expD[i]);
         else nPass++;
      end
      pulseAbort();
      nChecks++; if (bus.state !== 2'd0)      $display("FAIL ovr_abort_state got %0d want 0", bus.state); else nPass++;
      nChecks++; if (bus.overrun !== 4'b0001) $display("FAIL ovr_kept got %b want 0001", bus.overrun); else nPass++;
   endtask

   task automatic test_abort_rearm();
      int nW   = 0;
      bit sent = 0;
      int base;
      pulseArm();
      nChecks++; if (bus.overrun !== 4'b0000) $display("FAIL abt_overrun_cleared got %b want 0000", bus.overrun); else nPass++;
      bus.force_trig = 1'b1;
      setFrame(1, 2, 3, 4, 4'b1111);
      cyc();
      bus.force_trig = 1'b0;
      clearValids();
      for (int i = 0; i < 20 && nW < 5; i++) begin
         cyc();
         clearValids();
         if (bus.wr_en === 1'b1) nW++;
         if (nW == 4 && !sent) begin
            setFrame(5, 6, 7, 8, 4'b1111);
            sent = 1;
         end
      end
      nChecks++; if (nW != 5) $display("FAIL abt_write_count got %0d want 5", nW); else nPass++;
      nChecks++; if (bus.wr_addr !== 12'd4 || bus.wr_data !== 16'd5)
         $display("FAIL abt_fifth_write got addr=%0d data=%0d want addr=4 data=5", bus.wr_addr, bus.wr_data);
      else nPass++;
      pulseAbort();
      nChecks++; if (bus.state !== 2'd0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL abt_idle got state=%0d en=%b busy=%b want 0 0 0", bus.state, bus.wr_en, bus.busy);
      else nPass++;
      base = wrCount;
      repeat (6) cyc();
      nChecks++; if (wrCount != base) $display("FAIL abt_no_writes got %0d want 0", wrCount - base); else nPass++;
      pulseArm();
      bus.force_trig = 1'b1;
      setFrame(77, 0, 0, 0, 4'b0001);
      cyc();
      bus.force_trig = 1'b0;
      clearValids();
      cyc();
      nChecks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== '0 || bus.wr_data !== 16'd77)
         $display("FAIL abt_rearm_write got en=%b addr=%0d data=%0d want en=1 addr=0 data=77", bus.wr_en, bus.wr_addr, bus.wr_data);
      else nPass++;
      pulseAbort();
   endtask

   task automatic test_full_record();
      int base;
      int rdyDuringWrite = 0;
      logic [DATA_W-1:0] expD;
      pulseArm();
      bus.force_trig = 1'b1;
      cyc();
      bus.force_trig = 1'b0;
      nChecks++; if (bus.state !== 2'd2) $display("FAIL full_capture got %0d want 2", bus.state); else nPass++;
      base = wrCount;
      for (int f = 0; f < 4; f++) begin
         setFrame(f * 100 - 50, f * 100 - 87, f * 100 - 124, f * 100 - 161, 4'b1111);
         cyc();
         clearValids();
         repeat (7) cyc();
      end
      nChecks++; if (wrCount - base != 16) $display("FAIL full_write_count got %0d want 16", wrCount - base); else nPass++;
      for (int i = 0; i < 16 && base + i < wrCount; i++) begin
         expD = DATA_W'((i / 4) * 100 - (i % 4) * 37 - 50);
         nChecks++; if (logAddr[base+i] !== ADDR_W'(i)) $display("FAIL full_addr[%0d] got %0d want %0d", i, logAddr[base+i], i); else nPass++;
         nChecks++; if (logData[base+i] !== expD) $display("FAIL full_data[%0d] got %0h want %0h", i, logData[base+i], expD); else nPass++;
         if (logRdy[base+i] !== 1'b0) rdyDuringWrite++;
      end
      nChecks++; if (rdyDuringWrite != 0) $display("FAIL full_rdy_early got %0d writes with data_rdy want 0", rdyDuringWrite); else nPass++;
      nChecks++; if (bus.state !== 2'd3)    $display("FAIL full_done got %0d want 3", bus.state); else nPass++;
      nChecks++; if (bus.data_rdy !== 1'b1) $display("FAIL full_data_rdy got %b want 1", bus.data_rdy); else nPass++;
      nChecks++; if (bus.busy !== 1'b0)     $display("FAIL full_busy got %b want 0", bus.busy); else nPass++;
      pulseArm();
      nChecks++; if (bus.state !== 2'd3) $display("FAIL full_arm_ignored got %0d want 3", bus.state); else nPass++;
      pulseAck();
      nChecks++; if (bus.state !== 2'd0 || bus.data_rdy !== 1'b0)
         $display("FAIL full_ack got state=%0d rdy=%b want 0 0", bus.state, bus.data_rdy);
      else nPass++;
   endtask

   task automatic test_async_reset();
      pulseArm();
      bus.force_trig = 1'b1;
      setFrame(101, 202, 303, 404, 4'b1111);
      cyc();
      bus.force_trig = 1'b0;
      clearValids();
      cyc();
      cyc();
      nChecks++; if (bus.wr_en !== 1'b1) $display("FAIL ares_burst got %b want 1", bus.wr_en); else nPass++;
      #2 rst = 1'b0;
      #1;
      nChecks++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0)
         $display("FAIL ares_port got en=%b addr=%0d data=%0d want 0 0 0", bus.wr_en, bus.wr_addr, bus.wr_data);
      else nPass++;
      nChecks++; if (bus.state !== 2'd0 || bus.busy !== 1'b0 || bus.data_rdy !== 1'b0 || bus.overrun !== 4'h0 || bus.trig_chan !== 4'h0)
         $display("FAIL ares_status got state=%0d busy=%b rdy=%b ovr=%b trig=%b want all 0",
                  bus.state, bus.busy, bus.data_rdy, bus.overrun, bus.trig_chan);
      else nPass++;
      cyc();
      rst = 1'b1;
      repeat (3) cyc();
      nChecks++; if (bus.state !== 2'd0 || bus.wr_en !== 1'b0)
         $display("FAIL ares_after got state=%0d en=%b want 0 0", bus.state, bus.wr_en);
      else nPass++;
   endtask

   initial begin
      test_reset();
      test_simultaneous();
      test_threshold_sat();
      test_overrun_rr();
      test_abort_rearm();
      test_full_record();
      test_async_reset();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no finish want finish before 200000");
      $fatal(1);
   end
endmodule
